fcp6_master: RTL and testbench

// - Bus initiator for the FCP6 link: turns one-byte read/write commands into START, header, data, ACK and STOP on the shared ctrl/data/ack wires.
// - Sits between the host command interface and the FCP6 slaves; the existing slave is its direct consumer.
// - One transaction in flight.
// - Write: 1 byte out, slave ACK expected. Read: 1 byte in, master ACKs.

---
 rtl/fcp6_pkg.sv | 30 +++
 rtl/fcp6_dibit_shifter.sv | 36 +++
 rtl/fcp6_master.sv | 199 +++++++++++++++++++
 tb/tb_fcp6_master.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fcp6_pkg.sv
// FCP6 link encodings and master state set, shared by the master and the slave.
package fcp6_pkg;

  localparam logic [1:0] CTRL_REL   = 2'b00;
  localparam logic [1:0] CTRL_START = 2'b01;
  localparam logic [1:0] CTRL_ACT   = 2'b10;
  localparam logic [1:0] CTRL_STOP  = 2'b11;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_HEADER     = 4'd2,
    ST_WAIT_ACK   = 4'd3,
    ST_WRITE_DATA = 4'd4,
    ST_WAIT_ACK2  = 4'd5,
    ST_READ_WAIT  = 4'd6,
    ST_READ_DATA  = 4'd7,
    ST_SEND_ACK   = 4'd8,
    ST_STOP       = 4'd9,
    ST_DONE       = 4'd10
  } fcp6_state_e;

  function automatic logic [7:0] fcp6_header(input logic [6:0] addr, input logic write);
    return {addr, write};
  endfunction

endpackage

// File: rtl/fcp6_dibit_shifter.sv
// 8-bit dibit shifter: MSB dibit out, dibit in at the bottom, with a 2-bit
// position index; used for header/write-data transmit and read-data receive.
module fcp6_dibit_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       shift,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic [7:0] value,
  output logic       done
);

  logic [7:0] sh_q;
  logic [1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (load) begin
      sh_q  <= load_val;
      idx_q <= '0;
    end else if (shift) begin
      sh_q  <= {sh_q[5:0], din};
      idx_q <= idx_q + 2'd1;
    end
  end

  assign dout  = sh_q[7:6];
  assign value = sh_q;
  // Asserted on the shift that completes a 4-dibit phase; index wraps to 0 there.
  assign done  = shift && (idx_q == 2'd3);

endmodule

// File: rtl/fcp6_master.sv
// FCP6 bus initiator: one-byte read/write transactions with ACK timeout and
// retry. State advances on posedge; pin drivers are registered on negedge.
module fcp6_master
  import fcp6_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned READ_GAP    = 2,
  parameter int unsigned MAX_RETRY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_write,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  inout  wire  [1:0] ctrl,
  inout  wire  [1:0] data,
  inout  wire        ack
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GW = $clog2(READ_GAP + 2);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  fcp6_state_e   state_q;
  logic [7:0]    hdr_q;
  logic [7:0]    wdata_q;
  logic          write_q;
  logic          err_q;
  logic          resend_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] tmo_q;
  logic [GW-1:0] gap_q;

  logic [1:0] ctrl_q, data_q;
  logic       ctrl_oe, data_oe, ack_oe, ack_q;

  logic       ack_seen;
  logic       sh_load, sh_shift, sh_done;
  logic [7:0] sh_load_val, sh_value;
  logic [1:0] sh_din, sh_dout;

  assign ack_seen = (ack == ACK);

  always_comb begin
    sh_load     = 1'b0;
    sh_load_val = hdr_q;
    sh_shift    = 1'b0;
    sh_din      = 2'b00;
    case (state_q)
      ST_START:      sh_load = 1'b1;
      ST_WAIT_ACK: begin
        sh_load     = ack_seen && write_q;
        sh_load_val = wdata_q;
      end
      ST_HEADER, ST_WRITE_DATA: sh_shift = 1'b1;
      ST_READ_DATA: begin
        sh_shift = 1'b1;
        sh_din   = data;
      end
      default: ;
    endcase
  end

  fcp6_dibit_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .din      (sh_din),
    .dout     (sh_dout),
    .value    (sh_value),
    .done     (sh_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hdr_q     <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      resend_q  <= 1'b0;
      retry_q   <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          hdr_q    <= fcp6_header(cmd_addr, cmd_write);
          wdata_q  <= cmd_wdata;
          write_q  <= cmd_write;
          err_q    <= 1'b0;
          resend_q <= 1'b0;
          retry_q  <= '0;
          state_q  <= ST_START;
        end
        ST_START: begin
          resend_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= ST_HEADER;
        end
        ST_HEADER: if (sh_done) state_q <= ST_WAIT_ACK;
        // A NACK is treated like silence; only the timeout ends the wait early.
        ST_WAIT_ACK, ST_WAIT_ACK2: begin
          if (ack_seen) begin
            tmo_q <= '0;
            gap_q <= '0;
            if (state_q == ST_WAIT_ACK2) state_q <= ST_STOP;
            else if (write_q)            state_q <= ST_WRITE_DATA;
            else                         state_q <= ST_READ_WAIT;
          end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            tmo_q   <= '0;
            state_q <= ST_STOP;
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q  <= retry_q + RW'(1);
              resend_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (tmo_q != TW'(ACK_TIMEOUT)) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WRITE_DATA: if (sh_done) state_q <= ST_WAIT_ACK2;
        ST_READ_WAIT: begin
          if (gap_q == GW'(READ_GAP - 1)) state_q <= ST_READ_DATA;
          else                            gap_q   <= gap_q + GW'(1);
        end
        ST_READ_DATA: if (sh_done) state_q <= ST_SEND_ACK;
        ST_SEND_ACK: begin
          rsp_rdata <= sh_value;
          state_q   <= ST_STOP;
        end
        ST_STOP: state_q <= resend_q ? ST_START : ST_DONE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pins follow the state registered at the preceding posedge, giving the slave half a cycle of setup.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ctrl_oe <= 1'b0;
      ctrl_q  <= CTRL_REL;
      data_oe <= 1'b0;
      data_q  <= 2'b00;
      ack_oe  <= 1'b0;
      ack_q   <= NACK;
    end else begin
      ctrl_oe <= 1'b0;
      ctrl_q  <= CTRL_REL;
      data_oe <= 1'b0;
      data_q  <= 2'b00;
      ack_oe  <= 1'b0;
      ack_q   <= NACK;
      case (state_q)
        ST_START: begin
          ctrl_oe <= 1'b1;
          ctrl_q  <= CTRL_START;
          data_oe <= 1'b1;
        end
        ST_HEADER, ST_WRITE_DATA: begin
          ctrl_oe <= 1'b1;
          ctrl_q  <= CTRL_ACT;
          data_oe <= 1'b1;
          data_q  <= sh_dout;
        end
        ST_SEND_ACK: begin
          ack_oe <= 1'b1;
          ack_q  <= ACK;
        end
        ST_STOP: begin
          ctrl_oe <= 1'b1;
          ctrl_q  <= CTRL_STOP;
        end
        default: ;
      endcase
    end
  end

  assign ctrl = ctrl_oe ? ctrl_q : 2'bzz;
  assign data = data_oe ? data_q : 2'bzz;
  assign ack  = ack_oe  ? ack_q  : 1'bz;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_fcp6_master.sv
// Directed bench for fcp6_master: the bench plays the slave on data/ack and
// checks pins after each negedge and handshake outputs after each posedge.
module tb_fcp6_master;
  import fcp6_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_ready, rsp_valid, rsp_err, busy;
  logic [7:0] rsp_rdata;
  wire  [1:0] ctrl, data;
  wire        ack;

  logic       s_ack_en, s_ack, s_data_en;
  logic [1:0] s_data;
  int         n_chk = 0;
  int         n_fail = 0;

  assign data = s_data_en ? s_data : 2'bzz;
  assign ack  = s_ack_en  ? s_ack  : 1'bz;

  always #5 clk = ~clk;

  fcp6_master #(.ACK_TIMEOUT(16), .READ_GAP(2), .MAX_RETRY(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .ctrl(ctrl), .data(data), .ack(ack)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic negc();
    @(negedge clk); #1;
  endtask

  task automatic posc();
    @(posedge clk); #1;
  endtask

  // Master enables and driven values; a transaction is in flight so cmd_ready must be low.
  task automatic pins(input string tag, input logic ce, input logic [1:0] cv,
                      input logic de, input logic [1:0] dv, input logic ae, input logic av);
    chk({tag, " oe"}, {5'b0, dut.ctrl_oe, dut.data_oe, dut.ack_oe}, {5'b0, ce, de, ae});
    chk({tag, " rdy"}, {7'b0, cmd_ready}, 8'h00);
    if (ce) chk({tag, " ctrl"}, {6'b0, ctrl}, {6'b0, cv});
    if (de) chk({tag, " data"}, {6'b0, data}, {6'b0, dv});
    if (ae) chk({tag, " ack"},  {7'b0, ack},  {7'b0, av});
  endtask

  task automatic rel(input string tag);
    pins(tag, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [6:0] a, input logic w, input logic [7:0] wd, input bit hold);
    cmd_addr = a; cmd_write = w; cmd_wdata = wd; cmd_valid = 1'b1;
    posc();
    chk("accept busy", {7'b0, busy}, 8'h01);
    chk("accept rdy", {7'b0, cmd_ready}, 8'h00);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic start_hdr(input logic [7:0] hdr);
    logic [7:0] t;
    negc(); pins("start", 1'b1, CTRL_START, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      negc(); t = hdr << (2 * i);
      pins("hdr", 1'b1, CTRL_ACT, 1'b1, t[7:6], 1'b0, 1'b0);
    end
  endtask

  task automatic finish_txn(input logic err, input logic [7:0] rd, input bit check_rd);
    posc();
    chk("rsp_valid", {7'b0, rsp_valid}, 8'h01);
    chk("rsp_err", {7'b0, rsp_err}, {7'b0, err});
    if (check_rd) chk("rsp_rdata", rsp_rdata, rd);
    negc(); rel("done");
    posc();
    chk("idle rdy", {7'b0, cmd_ready}, 8'h01);
    chk("idle rsp_valid", {7'b0, rsp_valid}, 8'h00);
  endtask

  task automatic write_body(input logic [7:0] hdr, input logic [7:0] wd, input int abort_at);
    logic [7:0] t;
    start_hdr(hdr);
    negc(); rel("wack"); s_ack_en = 1'b1; s_ack = ACK;
    for (int i = 0; i < 4; i++) begin
      negc(); s_ack_en = 1'b0; t = wd << (2 * i);
      pins("wdat", 1'b1, CTRL_ACT, 1'b1, t[7:6], 1'b0, 1'b0);
      if (i == abort_at) begin
        rst = 1'b1; #1;
        chk("rst oe", {5'b0, dut.ctrl_oe, dut.data_oe, dut.ack_oe}, 8'h00);
        chk("rst rdy", {7'b0, cmd_ready}, 8'h01);
        chk("rst busy", {7'b0, busy}, 8'h00);
        return;
      end
    end
    negc(); rel("wack2"); s_ack_en = 1'b1; s_ack = ACK;
    negc(); s_ack_en = 1'b0; pins("wstop", 1'b1, CTRL_STOP, 1'b0, 2'b00, 1'b0, 1'b0);
    finish_txn(1'b0, 8'h00, 1'b0);
  endtask

  task automatic read_body(input logic [7:0] hdr, input logic [7:0] rb);
    logic [7:0] t;
    start_hdr(hdr);
    negc(); rel("rack"); s_ack_en = 1'b1; s_ack = ACK;
    negc(); s_ack_en = 1'b0; rel("rgap0");
    negc(); rel("rgap1");
    for (int i = 0; i < 4; i++) begin
      negc(); rel("rdat"); t = rb << (2 * i);
      s_data_en = 1'b1; s_data = t[7:6];
    end
    negc(); s_data_en = 1'b0; pins("sack", 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, ACK);
    negc(); pins("rstop", 1'b1, CTRL_STOP, 1'b0, 2'b00, 1'b0, 1'b0);
    finish_txn(1'b0, rb, 1'b1);
  endtask

  task automatic silent_body(input logic [7:0] hdr);
    for (int r = 0; r < 2; r++) begin
      start_hdr(hdr);
      for (int c = 0; c < 16; c++) begin
        negc(); rel("nack wait"); s_ack_en = 1'b1; s_ack = NACK;
      end
      negc(); s_ack_en = 1'b0; pins("tmo stop", 1'b1, CTRL_STOP, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    finish_txn(1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    s_ack_en = 1'b0; s_ack = NACK; s_data_en = 1'b0; s_data = 2'b00;
    #2;
    chk("reset rdy", {7'b0, cmd_ready}, 8'h01);
    chk("reset busy", {7'b0, busy}, 8'h00);
    chk("reset rsp", {6'b0, rsp_valid, rsp_err}, 8'h00);
    chk("reset rdata", rsp_rdata, 8'h00);
    chk("reset oe", {5'b0, dut.ctrl_oe, dut.data_oe, dut.ack_oe}, 8'h00);
    negc(); rst = 1'b0;

    // Write 0x55 to 0x12: header 0x25.
    issue(7'h12, 1'b1, 8'h55, 1'b0);
    write_body(8'h25, 8'h55, -1);

    // Reads from 0x12 (header 0x24) and 0x2D (header 0x5A).
    issue(7'h12, 1'b0, 8'h00, 1'b0);
    read_body(8'h24, 8'h55);
    issue(7'h2D, 1'b0, 8'h00, 1'b0);
    read_body(8'h5A, 8'hC6);

    // Silent slave: timeout, one retry, then error.
    issue(7'h12, 1'b1, 8'hA5, 1'b0);
    silent_body(8'h25);
    chk("after err rdata", rsp_rdata, 8'hC6);

    // Reset during write data, then a clean write.
    issue(7'h33, 1'b1, 8'h0F, 1'b0);
    write_body(8'h67, 8'h0F, 1);
    for (int i = 0; i < 3; i++) begin
      posc(); chk("rst no rsp", {7'b0, rsp_valid}, 8'h00);
    end
    negc(); rst = 1'b0;
    posc(); chk("post rst rsp", {7'b0, rsp_valid}, 8'h00);
    issue(7'h33, 1'b1, 8'hF0, 1'b0);
    write_body(8'h67, 8'hF0, -1);

    // Back-to-back: cmd_valid held across the whole first transaction.
    issue(7'h7F, 1'b1, 8'h81, 1'b1);
    write_body(8'hFF, 8'h81, -1);
    posc();
    chk("b2b accept busy", {7'b0, busy}, 8'h01);
    chk("b2b accept rdy", {7'b0, cmd_ready}, 8'h00);
    cmd_valid = 1'b0;
    write_body(8'hFF, 8'h81, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
